// File: rtl/axi4_mem_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_mem_arbiter
//
// Shares one single-port word memory between NUM_REQ requesters (for example
// the AXI write-channel FSM, the read-channel FSM and a debug port). Grants
// are round-robin and held for a whole burst, so bursts never interleave.
// Read data is routed back to the requester that issued the read, even when
// the grant has already moved on.
//
// Ports:
//   ACLK, ARESETn          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready    per-requester beat handshake
//   req_we, req_last       per-requester write flag and end-of-burst flag
//   req_addr, req_wdata    packed per-requester word address / write data
//   rsp_valid, rsp_rdata   one-hot read response strobe, shared read data
//   mem_en, mem_we,        registered memory command, issued one cycle
//   mem_addr, mem_wdata    after the beat is accepted
//   mem_rdata              memory read data, valid the cycle after mem_en
//   owner, busy            current grant holder, high while a grant is held
//   err_overrun            one-cycle pulse when a burst hits MAX_BEATS
// ---------------------------------------------------------------------------
module axi4_mem_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int MAX_BEATS      = 256
) (
  input  logic                              ACLK,
  input  logic                              ARESETn,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0]                req_we,
  input  logic [NUM_REQ-1:0]                req_last,
  input  logic [NUM_REQ*MEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              mem_en,
  output logic                              mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  output logic [$clog2(NUM_REQ)-1:0]        owner,
  output logic                              busy,
  output logic                              err_overrun
);

  localparam int OW  = $clog2(NUM_REQ);
  localparam int OW1 = OW + 1;
  localparam int CW  = $clog2(MAX_BEATS) + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [OW-1:0] rr_ptr;
  logic [CW-1:0] beat_cnt;
  logic          grant_found;
  logic [OW-1:0] grant_idx;
  logic [OW:0]   cand;
  logic          accept;
  logic          release_last;
  logic          release_force;
  logic [OW-1:0] owner_inc;
  logic          tag1_rd, tag2_rd;
  logic [OW-1:0] tag1_owner, tag2_owner;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  // cand carries one extra bit so rr_ptr + i never overflows before the wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + OW1'(i);
      if (cand >= OW1'(NUM_REQ)) begin
        cand = cand - OW1'(NUM_REQ);
      end
      if (!grant_found && req_valid[cand[OW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[OW-1:0];
      end
    end
  end

  assign accept        = (state == LOCKED) && req_valid[owner];
  assign release_last  = accept && req_last[owner];
  // The MAX_BEATS-th beat without last still goes to memory, then the grant drops.
  assign release_force = accept && !req_last[owner] && (beat_cnt == CW'(MAX_BEATS - 1));
  assign owner_inc     = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign busy          = (state == LOCKED);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        req_ready[owner] = 1'b1;
        if (release_last || release_force) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      owner       <= '0;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      err_overrun <= 1'b0;
    end else begin
      err_overrun <= release_force;
      if ((state == IDLE) && grant_found) begin
        owner    <= grant_idx;
        beat_cnt <= '0;
      end
      if (accept) begin
        if (beat_cnt != {CW{1'b1}}) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        if (release_last || release_force) begin
          rr_ptr <= owner_inc;
        end
      end
    end
  end

  // Memory command register; address/data hold between accesses.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= accept;
      mem_we <= accept & req_we[owner];
      if (accept) begin
        mem_addr  <= req_addr[owner*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
        mem_wdata <= req_wdata[owner*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Read tag pipeline: stage 1 lines up with mem_en, stage 2 with mem_rdata.
  // The issuing owner travels with the tag so routing survives a grant change.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      tag1_rd    <= 1'b0;
      tag1_owner <= '0;
      tag2_rd    <= 1'b0;
      tag2_owner <= '0;
    end else begin
      tag1_rd    <= accept & ~req_we[owner];
      tag1_owner <= owner;
      tag2_rd    <= tag1_rd;
      tag2_owner <= tag1_owner;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (tag2_rd) begin
      rsp_valid[tag2_owner] = 1'b1;
    end
  end

  assign rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi4_mem_arbiter
//
// Directed bench for axi4_mem_arbiter with two requesters. Each requester is
// a small queue-driven driver; a transaction-level model (owner, round-robin
// pointer, beat count, shadow memory) predicts every output on every cycle,
// and each scenario ends with hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_axi4_mem_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MB = 256;

  logic             ACLK = 1'b0;
  logic             ARESETn = 1'b0;
  logic [NR-1:0]    req_valid, req_ready, req_we, req_last, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata, mem_wdata, mem_rdata;
  logic             mem_en, mem_we, busy, err_overrun;
  logic [AW-1:0]    mem_addr;
  logic [0:0]       owner;

  axi4_mem_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .MAX_BEATS(MB)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_last(req_last), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy), .err_overrun(err_overrun)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  // Behavioural single-port memory attached to the arbiter.
  logic [DW-1:0] ram [0:1023];
  always @(posedge ACLK) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  // ---------------- requester drivers ----------------
  typedef struct {
    bit            gap;
    bit            we;
    bit            last;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  bit    acc0, acc1;

  task automatic driveReq(input int r);
    beat_t b;
    bit    have;
    have = 1'b0;
    if (r == 0) begin
      if (acc0 && q0.size() > 0) void'(q0.pop_front());
      acc0 = 1'b0;
      if (q0.size() > 0 && q0[0].gap) void'(q0.pop_front());
      else if (q0.size() > 0) begin have = 1'b1; b = q0[0]; end
    end else begin
      if (acc1 && q1.size() > 0) void'(q1.pop_front());
      acc1 = 1'b0;
      if (q1.size() > 0 && q1[0].gap) void'(q1.pop_front());
      else if (q1.size() > 0) begin have = 1'b1; b = q1[0]; end
    end
    req_valid[r] = have;
    if (have) begin
      req_we[r]             = b.we;
      req_last[r]           = b.last;
      req_addr[r*AW +: AW]  = b.addr;
      req_wdata[r*DW +: DW] = b.wdata;
    end
  endtask

  initial begin
    req_valid = '0;
    req_we    = '0;
    req_last  = '0;
    req_addr  = '0;
    req_wdata = '0;
    forever begin
      @(posedge ACLK);
      #1;
      driveReq(0);
      driveReq(1);
    end
  end

  // ---------------- event logs from the DUT ----------------
  int            acc_own_log[$];
  int            acc_cyc_log[$];
  int            rsp_cyc_log[$];
  logic [NR-1:0] rsp_vec_log[$];
  logic [DW-1:0] rsp_dat_log[$];
  int            err_cyc_log[$];
  int            mem_addr_log[$];

  initial forever begin
    @(negedge ACLK);
    if (ARESETn) begin
      acc0 = req_valid[0] & req_ready[0];
      acc1 = req_valid[1] & req_ready[1];
      if (acc0) begin acc_own_log.push_back(0); acc_cyc_log.push_back(cyc); end
      if (acc1) begin acc_own_log.push_back(1); acc_cyc_log.push_back(cyc); end
      if (rsp_valid != '0) begin
        rsp_cyc_log.push_back(cyc);
        rsp_vec_log.push_back(rsp_valid);
        rsp_dat_log.push_back(rsp_rdata);
      end
      if (err_overrun) err_cyc_log.push_back(cyc);
      if (mem_en) mem_addr_log.push_back(int'(mem_addr));
    end
  end

  task automatic clearLogs();
    acc_own_log.delete();
    acc_cyc_log.delete();
    rsp_cyc_log.delete();
    rsp_vec_log.delete();
    rsp_dat_log.delete();
    err_cyc_log.delete();
    mem_addr_log.delete();
  endtask

  // ---------------- transaction-level model + per-cycle compare ----------------
  logic [DW-1:0] shadow [0:1023];
  bit            m_locked;
  int            m_owner, m_rr, m_cnt;
  bit            e_en, e_we, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  bit            s1_v, s2_v;
  int            s1_o, s2_o;
  logic [DW-1:0] s1_d, s2_d;

  initial forever begin
    @(negedge ACLK);
    if (!ARESETn) begin
      checkOutput("rst_ctrl", {busy, req_ready, rsp_valid, mem_en, mem_we, err_overrun, owner}, '0);
      checkOutput("rst_mem", {mem_addr, mem_wdata}, '0);
      m_locked = 0; m_owner = 0; m_rr = 0; m_cnt = 0;
      e_en = 0; e_we = 0; e_err = 0;
      s1_v = 0; s2_v = 0;
    end else begin
      logic [NR-1:0] exp_ready, exp_rsp;
      bit            acc, found;
      int            o;
      logic [AW-1:0] a;
      exp_ready = '0;
      if (m_locked) exp_ready[m_owner] = 1'b1;
      exp_rsp = '0;
      if (s2_v) exp_rsp[s2_o] = 1'b1;
      checkOutput("busy", busy, m_locked);
      checkOutput("req_ready", req_ready, exp_ready);
      if (m_locked) checkOutput("owner", owner, m_owner);
      checkOutput("mem_en", mem_en, e_en);
      checkOutput("mem_we", mem_we, e_en & e_we);
      if (e_en) checkOutput("mem_addr", mem_addr, e_addr);
      if (e_en && e_we) checkOutput("mem_wdata", mem_wdata, e_wdata);
      checkOutput("err_overrun", err_overrun, e_err);
      checkOutput("rsp_valid", rsp_valid, exp_rsp);
      if (s2_v) checkOutput("rsp_rdata", rsp_rdata, s2_d);

      acc  = m_locked && req_valid[m_owner];
      s2_v = s1_v; s2_o = s1_o; s2_d = s1_d;
      s1_v = 0;
      e_en = acc; e_we = 0; e_err = 0;
      if (acc) begin
        o       = m_owner;
        a       = req_addr[o*AW +: AW];
        e_we    = req_we[o];
        e_addr  = a;
        e_wdata = req_wdata[o*DW +: DW];
        if (req_we[o]) shadow[a] = e_wdata;
        else begin s1_v = 1; s1_o = o; s1_d = shadow[a]; end
        m_cnt++;
        if (req_last[o]) begin
          m_locked = 0; m_rr = (o + 1) % NR;
        end else if (m_cnt == MB) begin
          m_locked = 0; m_rr = (o + 1) % NR; e_err = 1;
        end
      end else if (!m_locked) begin
        found = 0;
        for (int k = 0; k < NR; k++) begin
          if (!found && req_valid[(m_rr + k) % NR]) begin
            found = 1; m_owner = (m_rr + k) % NR; m_locked = 1; m_cnt = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input int r, input bit gap, input bit we, input bit last,
                               input int addr, input logic [DW-1:0] wdata);
    beat_t b;
    b.gap = gap; b.we = we; b.last = last; b.addr = AW'(addr); b.wdata = wdata;
    if (r == 0) q0.push_back(b);
    else        q1.push_back(b);
  endtask

  task automatic waitIdle(input string name, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge ACLK);
      #1;
      if (q0.size() == 0 && q1.size() == 0 && !busy) done = 1;
    end
    if (!done) checkOutput({name, "_timeout"}, 1, 0);
    repeat (4) @(negedge ACLK);
  endtask

  task automatic resetDut();
    @(negedge ACLK);
    #1;
    ARESETn = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) @(posedge ACLK);
    #2;
    ARESETn = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bit got2;
    for (int i = 0; i < 1024; i++) begin
      ram[i]    = 32'hDEAD_0000 | 32'(i);
      shadow[i] = 32'hDEAD_0000 | 32'(i);
    end
    ram[7]    = 32'h0000_1234;
    shadow[7] = 32'h0000_1234;

    repeat (3) @(posedge ACLK);
    #2;
    ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);

    // Single write then read by requester 0.
    clearLogs();
    applyStimulus(0, 0, 1, 1, 5, 32'hA5A5_0001);
    waitIdle("t1_wr", 50);
    applyStimulus(0, 0, 0, 1, 5, 32'h0);
    waitIdle("t1_rd", 50);
    checkOutput("t1_acc_count", acc_own_log.size(), 2);
    checkOutput("t1_mem_count", mem_addr_log.size(), 2);
    if (mem_addr_log.size() == 2) checkOutput("t1_mem_addr", mem_addr_log[1], 5);
    checkOutput("t1_rsp_count", rsp_cyc_log.size(), 1);
    if (rsp_cyc_log.size() == 1 && acc_cyc_log.size() == 2) begin
      checkOutput("t1_rsp_vec", rsp_vec_log[0], 2'b01);
      checkOutput("t1_rsp_data", rsp_dat_log[0], 32'hA5A5_0001);
      checkOutput("t1_rsp_latency", rsp_cyc_log[0] - acc_cyc_log[1], 2);
    end

    // Contention from reset: two 4-beat write bursts.
    resetDut();
    clearLogs();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, (i == 3), 16 + i, 32'h200 + 32'(i));
      applyStimulus(1, 0, 1, (i == 3), 32 + i, 32'h300 + 32'(i));
    end
    waitIdle("t2_burst", 60);
    checkOutput("t2_acc_count", acc_own_log.size(), 8);
    if (acc_own_log.size() == 8 && mem_addr_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        checkOutput("t2_owner_seq", acc_own_log[i], (i < 4) ? 0 : 1);
        checkOutput("t2_addr_seq", mem_addr_log[i], (i < 4) ? 16 + i : 28 + i);
      end
      checkOutput("t2_turnaround", acc_cyc_log[4] - acc_cyc_log[3], 2);
    end
    clearLogs();
    applyStimulus(0, 0, 1, 1, 40, 32'h4040);
    applyStimulus(1, 0, 1, 1, 41, 32'h4141);
    waitIdle("t2_next", 40);
    if (acc_own_log.size() == 2) begin
      checkOutput("t2_next_first", acc_own_log[0], 0);
      checkOutput("t2_next_second", acc_own_log[1], 1);
    end else checkOutput("t2_next_count", acc_own_log.size(), 2);

    // Read routing across a grant change.
    clearLogs();
    applyStimulus(1, 0, 0, 1, 7, 32'h0);
    @(negedge ACLK);
    applyStimulus(0, 0, 1, 1, 50, 32'h5050);
    waitIdle("t3_route", 40);
    checkOutput("t3_rsp_count", rsp_cyc_log.size(), 1);
    if (rsp_cyc_log.size() == 1) begin
      checkOutput("t3_rsp_vec", rsp_vec_log[0], 2'b10);
      checkOutput("t3_rsp_data", rsp_dat_log[0], 32'h1234);
    end
    if (acc_own_log.size() == 2) begin
      checkOutput("t3_first_owner", acc_own_log[0], 1);
      checkOutput("t3_second_owner", acc_own_log[1], 0);
    end else checkOutput("t3_acc_count", acc_own_log.size(), 2);

    // Bubble of 3 cycles between beats 2 and 3.
    clearLogs();
    applyStimulus(0, 0, 1, 0, 60, 32'h60);
    applyStimulus(0, 0, 1, 0, 61, 32'h61);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 1, 0, 62, 32'h62);
    applyStimulus(0, 0, 1, 1, 63, 32'h63);
    @(negedge ACLK);
    applyStimulus(1, 0, 1, 1, 70, 32'h70);
    waitIdle("t4_bubble", 60);
    checkOutput("t4_mem_count", mem_addr_log.size(), 5);
    if (acc_own_log.size() == 5) begin
      for (int i = 0; i < 5; i++) checkOutput("t4_owner_seq", acc_own_log[i], (i < 4) ? 0 : 1);
      checkOutput("t4_gap", acc_cyc_log[2] - acc_cyc_log[1], 4);
    end else checkOutput("t4_acc_count", acc_own_log.size(), 5);

    // Overrun: 257 beats, only the last carries req_last.
    clearLogs();
    for (int i = 0; i < 257; i++) applyStimulus(0, 0, 1, (i == 256), i, 32'hC000_0000 + 32'(i));
    waitIdle("t5_overrun", 700);
    checkOutput("t5_err_count", err_cyc_log.size(), 1);
    checkOutput("t5_acc_count", acc_own_log.size(), 257);
    if (err_cyc_log.size() == 1 && acc_cyc_log.size() == 257) begin
      checkOutput("t5_err_time", err_cyc_log[0] - acc_cyc_log[255], 1);
      checkOutput("t5_rearb", acc_cyc_log[256] - acc_cyc_log[255], 2);
    end

    // Reset in the middle of a read burst.
    clearLogs();
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, (i == 3), 100 + i, 32'h0);
    got2 = 0;
    for (int i = 0; i < 50 && !got2; i++) begin
      @(negedge ACLK);
      #1;
      if (acc_own_log.size() >= 2) got2 = 1;
    end
    if (!got2) checkOutput("t6_beat2_timeout", 1, 0);
    ARESETn = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    checkOutput("t6_async_ctrl", {busy, req_ready, rsp_valid, mem_en, mem_we, err_overrun, owner}, '0);
    checkOutput("t6_async_mem", {mem_addr, mem_wdata}, '0);
    repeat (2) @(posedge ACLK);
    #2;
    ARESETn = 1'b1;
    clearLogs();
    repeat (4) @(negedge ACLK);
    checkOutput("t6_no_rsp", rsp_cyc_log.size(), 0);
    checkOutput("t6_no_mem", mem_addr_log.size(), 0);
    applyStimulus(0, 0, 0, 1, 100, 32'h0);
    applyStimulus(1, 0, 0, 1, 101, 32'h0);
    waitIdle("t6_after", 40);
    if (acc_own_log.size() == 2) checkOutput("t6_first_grant", acc_own_log[0], 0);
    else checkOutput("t6_acc_count", acc_own_log.size(), 2);
    if (rsp_dat_log.size() == 2) begin
      checkOutput("t6_rsp0_data", rsp_dat_log[0], 32'hC000_0064);
      checkOutput("t6_rsp1_vec", rsp_vec_log[1], 2'b10);
      checkOutput("t6_rsp1_data", rsp_dat_log[1], 32'hC000_0065);
    end else checkOutput("t6_rsp_count", rsp_dat_log.size(), 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4_mem_arbiter.md
Name: axi4_mem_arbiter

Overview:
- Shares the single-port AXI slave memory (mem_en/mem_we/mem_addr/mem_wdata/mem_rdata) between NUM_REQ requesters, e.g. the write-channel FSM, the read-channel FSM and a debug/backdoor port.
- Grants are round-robin and locked per burst, so a burst is never interleaved with another requester's burst.
- Read responses are routed back to the requester that issued them.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DATA_WIDTH, 32, memory data width.
- MEM_ADDR_WIDTH, 10, word address width (clog2 of MEMORY_DEPTH=1024).
- MAX_BEATS, 256, maximum beats per grant before forced release.

Ports:
- ACLK  in  1  clock; all logic on its rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_ready  out  NUM_REQ  per-requester beat accept.
- req_we  in  NUM_REQ  1 = write beat, 0 = read beat.
- req_last  in  NUM_REQ  final beat of burst.
- req_addr  in  NUM_REQ*MEM_ADDR_WIDTH  packed word addresses; requester i at slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- rsp_valid  out  NUM_REQ  read data valid, one-hot per requester.
- rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  MEM_ADDR_WIDTH  memory word address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_en.
- owner  out  clog2(NUM_REQ)  current grant holder; meaningful when busy=1.
- busy  out  1  1 in LOCKED.
- err_overrun  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async, ARESETn=0), all outputs and state cleared:
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
  - req_ready=0, rsp_valid=0, rsp pipeline tags cleared.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, err_overrun=0.
  - In-flight reads are dropped.
- FSM states: IDLE, LOCKED.
- IDLE:
  - req_ready all 0.
  - If any req_valid: owner <= first asserted index searching from rr_ptr upward with wrap; beat_cnt <= 0; go to LOCKED.
  - Otherwise stay in IDLE.
  - Minimum turnaround is 1 cycle.
- LOCKED:
  - req_ready[owner]=1 combinationally; all other req_ready=0.
  - A beat is accepted when req_valid[owner] & req_ready[owner].
  - Owner dropping req_valid mid-burst: remain LOCKED, no memory access issued.
- Accepted beat at cycle T:
  - At T+1: mem_en=1, mem_we=req_we[owner], mem_addr and mem_wdata registered from owner's slice.
  - mem_en/mem_we default to 0 in every other cycle.
- Read response:
  - 2-stage tag pipeline carries {is_read, owner}.
  - rsp_valid[tag_owner]=1 at T+2, with rsp_rdata = mem_rdata passed through.
  - No backpressure; the requester must accept.
  - Correct routing holds even if the grant has moved to another requester.
- Writes produce no rsp_valid.
- Release:
  - On an accepted beat with req_last=1: next state IDLE, rr_ptr <= owner+1 (mod NUM_REQ).
  - beat_cnt increments per accepted beat, saturating width clog2(MAX_BEATS)+1.
  - If an accepted beat is the MAX_BEATS-th without req_last: forced release to IDLE, err_overrun pulses 1 cycle at T+1, rr_ptr advances. The beat itself is still performed.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than (NUM_REQ-1) bursts.
- Single-beat burst (req_last on first beat): LOCKED for exactly 1 cycle if valid is held.
- Asynchronous reset mid-burst: immediate return to reset values. Any pending rsp_valid is suppressed.

Test Plan:
- Single write then read, requester 0: write addr 5 data 0xA5A5_0001 (last=1), then read addr 5 (last=1) -> mem_en/mem_we pulses at T+1; rsp_valid[0]=1 with rsp_rdata=0xA5A5_0001 exactly 2 cycles after the read accept; rsp_valid[1] stays 0.
- Contention: req 0 and req 1 both valid from reset, each issuing a 4-beat write burst -> owner=0 for 4 accepted beats, 1 IDLE cycle, then owner=1 for 4 beats; no interleaving on mem_addr; next contended grant goes to 0.
- Read routing across grant change: req 1 single read of addr 7 (preloaded 0x1234) immediately followed by a grant to req 0 -> rsp_valid[1] (not [0]) pulses with 0x1234.
- Bubble mid-burst: owner drops req_valid for 3 cycles between beats 2 and 3 of a 4-beat burst -> busy stays 1, req_ready[owner] stays 1, no mem_en during the gap, other requester not granted.
- Overrun: req 0 issues 257 beats without req_last -> forced release after beat 256, err_overrun 1-cycle pulse, beat 257 accepted only after re-arbitration.
- Reset mid-burst: assert ARESETn=0 during beat 2 of a read burst -> all outputs 0 asynchronously, no rsp_valid after release; the first grant after reset goes to requester 0.
